// File: rtl/univ_resp_checker.sv
// -----------------------------------------------------------------------------
// univ_resp_checker
//
// Self-contained stimulus/response checker for the universal combinational
// test set (AND, half adder, full adder, 2x1 mux, 4x1 mux). It walks an
// exhaustive vector sequence into the attached DUT, waits SETTLE_CYC cycles
// for the DUT to settle, samples its outputs and compares them against a
// built-in golden model. Mismatches are counted (saturating) and a pass flag
// is presented once the sequence is complete.
//
// Parameters:
//   MODULE_SELECT  0=AND, 1=half adder, 2=full adder, 3=mux_2x1, 4=mux_4x1
//   SETTLE_CYC     settle cycles per vector, legal range 1..15
//   ERR_W          width of the mismatch counter
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_start               start request, honoured only in IDLE or DONE
//   o_a,o_b,o_c,o_d,o_sel stimulus to the DUT (vector index bits 0..5)
//   i_y1, i_y2            DUT outputs (y/sum, carry)
//   o_busy, o_done        sequence in progress / complete (held until start)
//   o_pass                1 when done with zero mismatches
//   o_err_cnt             saturating mismatch count
//   o_vec_idx             index of the vector currently driven
//
// Optional feature (macro UNIV_CHK_FIRSTFAIL_EN):
//   o_ff_valid, o_ff_vec, o_ff_y capture the index and {i_y2,i_y1} of the
//   first mismatch of a run; held until the next start or reset.
// -----------------------------------------------------------------------------
module univ_resp_checker #(
    parameter int MODULE_SELECT = 2,
    parameter int SETTLE_CYC    = 2,
    parameter int ERR_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c,
    output logic             o_d,
    output logic [1:0]       o_sel,
    input  logic             i_y1,
    input  logic             i_y2,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
`ifdef UNIV_CHK_FIRSTFAIL_EN
    output logic             o_ff_valid,
    output logic [5:0]       o_ff_vec,
    output logic [1:0]       o_ff_y,
`endif
    output logic [5:0]       o_vec_idx
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // An unknown MODULE_SELECT runs a single vector that always mismatches.
    localparam int NUM_VEC = (MODULE_SELECT == 0 || MODULE_SELECT == 1) ? 4  :
                             (MODULE_SELECT == 2 || MODULE_SELECT == 3) ? 8  :
                             (MODULE_SELECT == 4)                       ? 64 : 1;
    localparam logic [5:0] LAST_IDX = 6'(NUM_VEC - 1);

    // Stimulus bits the selected DUT type does not use are forced to 0.
    localparam logic [5:0] STIM_MASK = (MODULE_SELECT <= 1) ? 6'b000011 :
                                       (MODULE_SELECT <= 3) ? 6'b000111 :
                                       (MODULE_SELECT == 4) ? 6'b111111 : 6'b000000;

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

    logic [2:0]       state_q, state_d;
    logic [5:0]       idx_q,   idx_d;
    logic [5:0]       stim_q,  stim_d;   // {sel[1:0], d, c, b, a}
    logic [3:0]       cnt_q,   cnt_d;
    logic [ERR_W-1:0] err_q,   err_d;
`ifdef UNIV_CHK_FIRSTFAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [5:0]       ff_vec_q,   ff_vec_d;
    logic [1:0]       ff_y_q,     ff_y_d;
`endif

    // Golden model, evaluated on the registered stimulus.
    logic exp_y1, exp_y2, chk_y2, model_ok, mismatch;

    always_comb begin
        exp_y1   = 1'b0;
        exp_y2   = 1'b0;
        chk_y2   = 1'b0;
        model_ok = 1'b1;
        case (MODULE_SELECT)
            0: exp_y1 = stim_q[0] & stim_q[1];
            1: begin
                exp_y1 = stim_q[0] ^ stim_q[1];
                exp_y2 = stim_q[0] & stim_q[1];
                chk_y2 = 1'b1;
            end
            2: begin
                exp_y1 = stim_q[0] ^ stim_q[1] ^ stim_q[2];
                exp_y2 = (stim_q[0] & stim_q[1]) | (stim_q[0] & stim_q[2]) |
                         (stim_q[1] & stim_q[2]);
                chk_y2 = 1'b1;
            end
            3: exp_y1 = stim_q[2] ? stim_q[1] : stim_q[0];
            4: exp_y1 = stim_q[stim_q[5:4]];
            default: model_ok = 1'b0;
        endcase
    end

    // Case-inequality so that X/Z from the DUT is counted as a mismatch in
    // simulation; synthesis treats it as an ordinary inequality. Both outputs
    // wrong still counts as a single mismatch for the vector.
    assign mismatch = !model_ok || (i_y1 !== exp_y1) || (chk_y2 && (i_y2 !== exp_y2));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stim_d  = stim_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
`ifdef UNIV_CHK_FIRSTFAIL_EN
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        ff_y_d     = ff_y_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_DRIVE;
                    idx_d   = 6'd0;
                    stim_d  = 6'd0;   // vector 0 is all zeros for every type
                    err_d   = '0;
`ifdef UNIV_CHK_FIRSTFAIL_EN
                    ff_valid_d = 1'b0;
                    ff_vec_d   = 6'd0;
                    ff_y_d     = 2'd0;
`endif
                end
            end
            S_DRIVE: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LOAD;
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    err_d = (err_q == ERR_MAX) ? err_q : err_q + ERR_W'(1);
`ifdef UNIV_CHK_FIRSTFAIL_EN
                    if (!ff_valid_q) begin
                        ff_valid_d = 1'b1;
                        ff_vec_d   = idx_q;
                        ff_y_d     = {i_y2, i_y1};
                    end
`endif
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;   // stimulus keeps the last vector
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + 6'd1;
                    stim_d  = (idx_q + 6'd1) & STIM_MASK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
            stim_q  <= 6'd0;
            cnt_q   <= 4'd0;
            err_q   <= '0;
`ifdef UNIV_CHK_FIRSTFAIL_EN
            ff_valid_q <= 1'b0;
            ff_vec_q   <= 6'd0;
            ff_y_q     <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            stim_q  <= stim_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef UNIV_CHK_FIRSTFAIL_EN
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
            ff_y_q     <= ff_y_d;
`endif
        end
    end

    assign o_a       = stim_q[0];
    assign o_b       = stim_q[1];
    assign o_c       = stim_q[2];
    assign o_d       = stim_q[3];
    assign o_sel     = stim_q[5:4];
    assign o_busy    = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_CHECK);
    assign o_done    = (state_q == S_DONE);
    assign o_pass    = o_done && (err_q == '0);
    assign o_err_cnt = err_q;
    assign o_vec_idx = idx_q;
`ifdef UNIV_CHK_FIRSTFAIL_EN
    assign o_ff_valid = ff_valid_q;
    assign o_ff_vec   = ff_vec_q;
    assign o_ff_y     = ff_y_q;
`endif

endmodule

// File: tb/tb_univ_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_univ_resp_checker
//
// Three checker instances, each with a behavioural DUT beside it:
//   fa : full adder, SETTLE_CYC=2, ERR_W=8, fault modes (carry stuck-0)
//   mx : mux_4x1, fault mode swaps d1/d2
//   st : full adder with y1 inverted, ERR_W=2 (counter saturation)
// Expected run results are queued when a run is started; monitors pop and
// compare them when o_done rises. Further monitors check stimulus/index
// stepping while busy.
// -----------------------------------------------------------------------------
module tb_univ_resp_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_fa, start_mx, start_st;
    int   fa_mode, mx_mode;

    logic fa_a, fa_b, fa_c, fa_d, fa_y1, fa_y2, fa_busy, fa_done, fa_pass;
    logic [1:0] fa_sel; logic [7:0] fa_err; logic [5:0] fa_idx;
    logic fa_ffv; logic [5:0] fa_ffvec; logic [1:0] fa_ffy;

    logic mx_a, mx_b, mx_c, mx_d, mx_y1, mx_y2, mx_busy, mx_done, mx_pass;
    logic [1:0] mx_sel; logic [7:0] mx_err; logic [5:0] mx_idx;
    logic mx_ffv; logic [5:0] mx_ffvec; logic [1:0] mx_ffy;

    logic st_a, st_b, st_c, st_d, st_y1, st_y2, st_busy, st_done, st_pass;
    logic [1:0] st_sel; logic [1:0] st_err; logic [5:0] st_idx;
    logic st_ffv; logic [5:0] st_ffvec; logic [1:0] st_ffy;

    // Behavioural DUTs
    assign fa_y1 = fa_a ^ fa_b ^ fa_c ^ (fa_mode == 2);
    assign fa_y2 = (fa_mode == 1) ? 1'b0 : ((fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c));
    always_comb begin
        mx_y1 = 1'b0;
        case (mx_sel)
            2'd0: mx_y1 = mx_a;
            2'd1: mx_y1 = (mx_mode == 1) ? mx_c : mx_b;
            2'd2: mx_y1 = (mx_mode == 1) ? mx_b : mx_c;
            default: mx_y1 = mx_d;
        endcase
    end
    assign mx_y2 = 1'b0;
    assign st_y1 = ~(st_a ^ st_b ^ st_c);
    assign st_y2 = (st_a & st_b) | (st_a & st_c) | (st_b & st_c);

    univ_resp_checker #(.MODULE_SELECT(2), .SETTLE_CYC(2), .ERR_W(8)) u_fa (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_fa),
        .o_a(fa_a), .o_b(fa_b), .o_c(fa_c), .o_d(fa_d), .o_sel(fa_sel),
        .i_y1(fa_y1), .i_y2(fa_y2), .o_busy(fa_busy), .o_done(fa_done),
        .o_pass(fa_pass), .o_err_cnt(fa_err),
`ifdef UNIV_CHK_FIRSTFAIL_EN
        .o_ff_valid(fa_ffv), .o_ff_vec(fa_ffvec), .o_ff_y(fa_ffy),
`endif
        .o_vec_idx(fa_idx));

    univ_resp_checker #(.MODULE_SELECT(4), .SETTLE_CYC(2), .ERR_W(8)) u_mx (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_mx),
        .o_a(mx_a), .o_b(mx_b), .o_c(mx_c), .o_d(mx_d), .o_sel(mx_sel),
        .i_y1(mx_y1), .i_y2(mx_y2), .o_busy(mx_busy), .o_done(mx_done),
        .o_pass(mx_pass), .o_err_cnt(mx_err),
`ifdef UNIV_CHK_FIRSTFAIL_EN
        .o_ff_valid(mx_ffv), .o_ff_vec(mx_ffvec), .o_ff_y(mx_ffy),
`endif
        .o_vec_idx(mx_idx));

    univ_resp_checker #(.MODULE_SELECT(2), .SETTLE_CYC(2), .ERR_W(2)) u_st (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_st),
        .o_a(st_a), .o_b(st_b), .o_c(st_c), .o_d(st_d), .o_sel(st_sel),
        .i_y1(st_y1), .i_y2(st_y2), .o_busy(st_busy), .o_done(st_done),
        .o_pass(st_pass), .o_err_cnt(st_err),
`ifdef UNIV_CHK_FIRSTFAIL_EN
        .o_ff_valid(st_ffv), .o_ff_vec(st_ffvec), .o_ff_y(st_ffy),
`endif
        .o_vec_idx(st_idx));

`ifndef UNIV_CHK_FIRSTFAIL_EN
    assign {fa_ffv, fa_ffvec, fa_ffy} = '0;
    assign {mx_ffv, mx_ffvec, mx_ffy} = '0;
    assign {st_ffv, st_ffvec, st_ffy} = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(string name, int act, int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endfunction

    typedef struct {
        int err;
        int pass;
        int busy;
        int ffv;
        int ffvec;
        int ffy;
    } exp_t;

    exp_t q_fa[$];
    exp_t q_mx[$];
    exp_t q_st[$];

    function automatic void compare_run(string tag, exp_t e, int err, int pass, int busy,
                                        int ffv, int ffvec, int ffy);
        $display("run %s: err=%0d pass=%0d busy_cycles=%0d (expected %0d/%0d/%0d)",
                 tag, err, pass, busy, e.err, e.pass, e.busy);
        chk({tag, "_err_cnt"}, err, e.err);
        chk({tag, "_pass"}, pass, e.pass);
        chk({tag, "_busy_cycles"}, busy, e.busy);
`ifdef UNIV_CHK_FIRSTFAIL_EN
        chk({tag, "_ff_valid"}, ffv, e.ffv);
        if (e.ffv != 0) begin
            chk({tag, "_ff_vec"}, ffvec, e.ffvec);
            chk({tag, "_ff_y"}, ffy, e.ffy);
        end
`endif
    endfunction

    // ---------------- done monitors (scoreboard pop) ----------------
    logic fa_done_p, mx_done_p, st_done_p, fa_busy_p, mx_busy_p, st_busy_p;
    int   fa_bcnt, mx_bcnt, st_bcnt, fa_hold;
    logic [5:0] fa_idx_p;
    exp_t e_fa, e_mx, e_st;

    always @(negedge clk) begin
        if (!rst_n) begin
            fa_done_p = 1'b0; fa_busy_p = 1'b0; fa_bcnt = 0; fa_hold = 0; fa_idx_p = 6'd0;
        end else begin
            if (fa_done && !fa_done_p) begin
                if (q_fa.size() == 0) chk("fa_unexpected_done", 1, 0);
                else begin
                    e_fa = q_fa.pop_front();
                    compare_run("fa", e_fa, int'(fa_err), int'(fa_pass), fa_bcnt,
                                int'(fa_ffv), int'(fa_ffvec), int'(fa_ffy));
                end
            end
            if (fa_busy) begin
                if (!fa_busy_p) begin
                    fa_bcnt = 0;
                    chk("fa_first_idx", int'(fa_idx), 0);
                    fa_hold = 0;
                end else if (fa_idx != fa_idx_p) begin
                    chk("fa_idx_step", int'(fa_idx), int'(fa_idx_p) + 1);
                    chk("fa_vec_hold", fa_hold, 4);
                    fa_hold = 0;
                end
                fa_hold++;
                fa_bcnt++;
                // Full adder uses a,b,c only; d and sel must stay 0.
                chk("fa_stim", int'({fa_sel, fa_d, fa_c, fa_b, fa_a}), int'(fa_idx));
            end
            fa_done_p = fa_done; fa_busy_p = fa_busy; fa_idx_p = fa_idx;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            mx_done_p = 1'b0; mx_busy_p = 1'b0; mx_bcnt = 0;
        end else begin
            if (mx_done && !mx_done_p) begin
                if (q_mx.size() == 0) chk("mx_unexpected_done", 1, 0);
                else begin
                    e_mx = q_mx.pop_front();
                    compare_run("mx", e_mx, int'(mx_err), int'(mx_pass), mx_bcnt,
                                int'(mx_ffv), int'(mx_ffvec), int'(mx_ffy));
                end
            end
            if (mx_busy) begin
                if (!mx_busy_p) mx_bcnt = 0;
                mx_bcnt++;
                chk("mx_stim", int'({mx_sel, mx_d, mx_c, mx_b, mx_a}), int'(mx_idx));
            end
            mx_done_p = mx_done; mx_busy_p = mx_busy;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            st_done_p = 1'b0; st_busy_p = 1'b0; st_bcnt = 0;
        end else begin
            if (st_done && !st_done_p) begin
                if (q_st.size() == 0) chk("st_unexpected_done", 1, 0);
                else begin
                    e_st = q_st.pop_front();
                    compare_run("st", e_st, int'(st_err), int'(st_pass), st_bcnt,
                                int'(st_ffv), int'(st_ffvec), int'(st_ffy));
                end
            end
            if (st_busy) begin
                if (!st_busy_p) st_bcnt = 0;
                st_bcnt++;
            end
            st_done_p = st_done; st_busy_p = st_busy;
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic done_of(int w);
        case (w)
            0: return fa_done;
            1: return mx_done;
            default: return st_done;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            0: start_fa = v;
            1: start_mx = v;
            default: start_st = v;
        endcase
    endtask

    task automatic pulse(input int w);
        @(negedge clk); set_start(w, 1'b1);
        @(negedge clk); set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input int limit);
        int n = 0;
        while (!done_of(w) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_timeout", int'(done_of(w)), 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start_fa = 1'b0; start_mx = 1'b0; start_st = 1'b0;
        fa_mode = 0; mx_mode = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("reset_fa_outs", int'({fa_a, fa_b, fa_c, fa_d, fa_sel, fa_busy, fa_done, fa_pass}), 0);
        chk("reset_fa_err", int'(fa_err), 0);
        chk("reset_fa_idx", int'(fa_idx), 0);
        chk("reset_fa_ff", int'({fa_ffv, fa_ffvec, fa_ffy}), 0);
        chk("reset_mx_outs", int'({mx_a, mx_b, mx_c, mx_d, mx_sel, mx_busy, mx_done, mx_pass}), 0);
        chk("reset_st_outs", int'({st_busy, st_done, st_pass, st_err, st_idx}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_busy", int'({fa_busy, fa_done, mx_busy, mx_done}), 0);

        // Correct full adder
        q_fa.push_back('{err: 0, pass: 1, busy: 32, ffv: 0, ffvec: 0, ffy: 0});
        pulse(0);
        wait_done(0, 100);

        // Carry stuck-at-0: vectors 3,5,6,7 mismatch; first at 3 with {y2,y1}=00
        fa_mode = 1;
        q_fa.push_back('{err: 4, pass: 0, busy: 32, ffv: 1, ffvec: 3, ffy: 0});
        pulse(0);
        wait_done(0, 100);

        // Correct mux_4x1: 64 vectors x 4 cycles
        q_mx.push_back('{err: 0, pass: 1, busy: 256, ffv: 0, ffvec: 0, ffy: 0});
        pulse(1);
        wait_done(1, 400);

        // d1/d2 swapped: sel in {1,2} with b!=c -> 16; first is idx 18, y=00
        mx_mode = 1;
        q_mx.push_back('{err: 16, pass: 0, busy: 256, ffv: 1, ffvec: 18, ffy: 0});
        pulse(1);
        wait_done(1, 400);

        // ERR_W=2, y1 inverted: 8 mismatches saturate at 3; first at idx 0, y=01
        q_st.push_back('{err: 3, pass: 0, busy: 32, ffv: 1, ffvec: 0, ffy: 1});
        pulse(2);
        wait_done(2, 100);

        // Reset mid-run at idx 5 aborts immediately
        fa_mode = 0;
        pulse(0);
        n = 0;
        while (fa_idx != 6'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("fa_reach_idx5", int'(fa_idx), 5);
        rst_n = 1'b0;
        #1;
        chk("abort_fa_outs", int'({fa_a, fa_b, fa_c, fa_d, fa_sel, fa_busy, fa_done, fa_pass}), 0);
        chk("abort_fa_err_idx", int'({fa_err, fa_idx}), 0);
        chk("abort_fa_ff", int'({fa_ffv, fa_ffvec, fa_ffy}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q_fa.push_back('{err: 0, pass: 1, busy: 32, ffv: 0, ffvec: 0, ffy: 0});
        pulse(0);
        wait_done(0, 100);

        // i_start held high: no restart while busy; restart from DONE clears err
        fa_mode = 1;
        q_fa.push_back('{err: 4, pass: 0, busy: 32, ffv: 1, ffvec: 3, ffy: 0});
        q_fa.push_back('{err: 0, pass: 1, busy: 32, ffv: 0, ffvec: 0, ffy: 0});
        @(negedge clk);
        start_fa = 1'b1;
        @(negedge clk);
        wait_done(0, 100);
        chk("held_done_err", int'(fa_err), 4);
        fa_mode = 0;
        @(negedge clk);
        chk("restart_done_low", int'(fa_done), 0);
        chk("restart_busy", int'(fa_busy), 1);
        chk("restart_idx", int'(fa_idx), 0);
        chk("restart_err_clr", int'(fa_err), 0);
        start_fa = 1'b0;
        wait_done(0, 100);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q_fa.size() + q_mx.size() + q_st.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
